// File: rtl/acc_decoder_if.sv
// acc_decoder_if: sample-stream bundle for the accumulator decoder.
//   in_data/in_valid/in_ready    : accumulated-sample input handshake
//   out_data/out_valid/out_ready : recovered-data output handshake
// modport slave is the decoder side; modport master is the side that
// feeds samples in and consumes recovered data.
interface acc_decoder_if #(
    parameter int ACC_W  = 8,
    parameter int DATA_W = 4
);
    logic [ACC_W-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/acc_decoder.sv
// acc_decoder: inverts a triple-accumulator encoder (a1+=d, a2+=a1, a3+=a2,
// all mod 2^ACC_W) by taking three successive differences of the a3 stream.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous active-low reset
//   clr    : synchronous clear of history, output, err and count
//   bus    : acc_decoder_if.slave (in_* sample input, out_* recovered data)
//   err    : sticky flag, a recovered value did not fit in DATA_W bits
//   count  : accepted samples since reset/clr, saturating at 255
module acc_decoder #(
    parameter int ACC_W  = 8,
    parameter int DATA_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    acc_decoder_if.slave        bus,
    output logic                err,
    output logic [7:0]          count
);

    logic [ACC_W-1:0]  y1, c1r, c2r;
    logic [ACC_W-1:0]  c1, c2, d;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              in_ready_c;
    logic              accept;

    // Difference chain; all arithmetic wraps so encoder wrap-around cancels.
    always_comb begin
        c1         = bus.in_data - y1;
        c2         = c1 - c1r;
        d          = c2 - c2r;
        in_ready_c = (!out_valid_q || bus.out_ready) && !clr;
        accept     = bus.in_valid && in_ready_c;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    // History and output register; history only moves on an accept, so a
    // stalled output freezes the whole decoder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y1          <= '0;
            c1r         <= '0;
            c2r         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            y1          <= '0;
            c1r         <= '0;
            c2r         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            y1          <= bus.in_data;
            c1r         <= c1;
            c2r         <= c2;
            out_data_q  <= d[DATA_W-1:0];
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky overflow flag and saturating sample counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err   <= 1'b0;
            count <= '0;
        end else if (clr) begin
            err   <= 1'b0;
            count <= '0;
        end else if (accept) begin
            if (|d[ACC_W-1:DATA_W]) begin
                err <= 1'b1;
            end
            if (count != 8'hFF) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule
